// File: rtl/wb_matvec_engine.sv
// Wishbone NxN matrix-vector engine: input vector FIFO, a per-row dot-product datapath, and a result FIFO.
// Signed or unsigned arithmetic, with sticky input-overflow, accumulator-overflow and read-underflow flags.
module wb_matvec_engine #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int N         = 3,
  parameter int DW        = 8,
  parameter int ACC_W     = 16,
  parameter int IN_DEPTH  = 4,
  parameter int RES_DEPTH = 8
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_dat_i,
  input  logic [31:0] caravel_wb_adr_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o
);
  localparam int VW  = N * DW;
  localparam int SW  = ACC_W + 2;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int WCW = $clog2(N + 1);
  localparam int RW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [IAW:0]   IN_MAX  = (IAW+1)'(IN_DEPTH);
  localparam logic [RAW:0]   RES_MAX = (RAW+1)'(RES_DEPTH);
  localparam logic [WCW-1:0] W_MAX   = WCW'(N);
  localparam logic [RW-1:0]  R_LAST  = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMP} state_t;
  state_t state, state_nx;

  logic clk, rst;
  assign clk = caravel_wb_clk_i;
  assign rst = caravel_wb_rst_i;

  logic unused_bits;
  assign unused_bits = ^{caravel_wb_sel_i, caravel_wb_dat_i};

  logic [31:0] off, rdata;
  logic [2:0]  rsel;
  logic take, wr_ctrl, wr_w, wr_in, rd_res, clr;
  logic run, sgn, busy, wv;
  logic in_ovf, acc_ovf, res_udf;

  // A request is taken only while ack is low, so each bus cycle completes exactly once.
  assign off     = caravel_wb_adr_i - BASE_ADDRESS;
  assign rsel    = off[4:2];
  assign take    = caravel_wb_stb_i & caravel_wb_cyc_i & ~caravel_wb_ack_o
                 & (off < 32'd20) & (off[1:0] == 2'b00);
  assign wr_ctrl = take & caravel_wb_we_i & (rsel == 3'd0);
  assign wr_w    = take & caravel_wb_we_i & (rsel == 3'd2);
  assign wr_in   = take & caravel_wb_we_i & (rsel == 3'd3);
  assign rd_res  = take & ~caravel_wb_we_i & (rsel == 3'd4);
  assign clr     = wr_ctrl & caravel_wb_dat_i[1];

  // Weights
  logic [N-1:0][VW-1:0] w;
  logic [WCW-1:0]       w_cnt;
  assign wv = (w_cnt == W_MAX);

  // Input FIFO
  logic [VW-1:0]  in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wp, in_rp;
  logic [IAW:0]   in_cnt;
  logic in_full, in_empty, in_push, in_pop;
  assign in_full  = (in_cnt == IN_MAX);
  assign in_empty = (in_cnt == '0);
  assign in_push  = wr_in & ~in_full;

  // Result FIFO
  logic [ACC_W-1:0] res_mem [RES_DEPTH];
  logic [RAW-1:0]   res_wp, res_rp;
  logic [RAW:0]     res_cnt;
  logic res_full, res_empty, res_push, res_pop;
  assign res_full  = (res_cnt == RES_MAX);
  assign res_empty = (res_cnt == '0);
  assign res_pop   = rd_res & ~res_empty;

  // Datapath: one multiplier per column, products extended to SW bits before summing.
  logic [VW-1:0]        x_reg, row;
  logic [RW-1:0]        r;
  logic [N-1:0][SW-1:0] prod;
  logic [SW-1:0]        sum;
  logic                 ovf;
  assign row = w[r];

  for (genvar c = 0; c < N; c++) begin : g_lane
    logic [DW-1:0] a, b;
    logic [SW-1:0] ae, be;
    assign a       = row[c*DW +: DW];
    assign b       = x_reg[c*DW +: DW];
    assign ae      = sgn ? SW'($signed(a)) : SW'(a);
    assign be      = sgn ? SW'($signed(b)) : SW'(b);
    assign prod[c] = ae * be;
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < N; c++) sum = sum + prod[c];
  end

  // Signed overflow: bits above the ACC_W sign bit must all match it.
  assign ovf = sgn ? ~((&sum[SW-1:ACC_W-1]) | ~(|sum[SW-1:ACC_W-1]))
                   : (|sum[SW-1:ACC_W]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (clr) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (run && wv && !in_empty) state_nx = LOAD;
      LOAD: state_nx = COMP;
      COMP: if (res_push && r == R_LAST) state_nx = (run && !in_empty) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_pop   = (state == LOAD) & ~in_empty;
    res_push = (state == COMP) & ~res_full;
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r     <= '0;
      x_reg <= '0;
    end else if (in_pop) begin
      x_reg <= in_mem[in_rp];
      r     <= '0;
    end else if (res_push) begin
      r <= (r == R_LAST) ? '0 : r + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      in_wp <= '0; in_rp <= '0; in_cnt <= '0;
    end else begin
      if (in_push) begin
        in_mem[in_wp] <= caravel_wb_dat_i[VW-1:0];
        in_wp <= in_wp + 1'b1;
      end
      if (in_pop) in_rp <= in_rp + 1'b1;
      in_cnt <= in_cnt + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      res_wp <= '0; res_rp <= '0; res_cnt <= '0;
    end else begin
      if (res_push) begin
        res_mem[res_wp] <= sum[ACC_W-1:0];
        res_wp <= res_wp + 1'b1;
      end
      if (res_pop) res_rp <= res_rp + 1'b1;
      res_cnt <= res_cnt + (RAW+1)'(res_push) - (RAW+1)'(res_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      w <= '0; w_cnt <= '0;
      in_ovf <= 1'b0; acc_ovf <= 1'b0; res_udf <= 1'b0;
    end else begin
      if (wr_w && !wv) begin
        w[w_cnt] <= caravel_wb_dat_i[VW-1:0];
        w_cnt    <= w_cnt + 1'b1;
      end
      if (wr_in && in_full)     in_ovf  <= 1'b1;
      if (res_push && ovf)      acc_ovf <= 1'b1;
      if (rd_res && res_empty)  res_udf <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      3'd0: rdata = {29'd0, sgn, 1'b0, run};
      3'd1: rdata = {8'd0, 8'(res_cnt), 4'(in_cnt), 3'd0, res_udf, acc_ovf, in_ovf,
                     res_empty, res_full, in_empty, in_full, busy, wv};
      3'd4: if (!res_empty) rdata = sgn ? 32'($signed(res_mem[res_rp])) : 32'(res_mem[res_rp]);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      caravel_wb_ack_o <= 1'b0;
      caravel_wb_dat_o <= '0;
      run <= 1'b0;
      sgn <= 1'b0;
    end else begin
      caravel_wb_ack_o <= take;
      if (take) caravel_wb_dat_o <= caravel_wb_we_i ? '0 : rdata;
      if (wr_ctrl) begin
        run <= caravel_wb_dat_i[0];
        sgn <= caravel_wb_dat_i[2];
      end
    end
  end
endmodule

// File: tb/tb_wb_matvec_engine.sv
// Directed bench for wb_matvec_engine: reads queue their expected data, and a monitor compares on each read ack.
module tb_wb_matvec_engine;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [4:0] A_CTRL = 5'h00, A_STAT = 5'h04, A_WGT = 5'h08, A_IN = 5'h0C, A_RES = 5'h10;

  logic clk = 1'b0, rst = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_o;

  int checks = 0, failures = 0;
  logic [31:0] q_exp[$];
  string       q_name[$];
  logic        rd_flag = 1'b0;
  string       mon_n;
  logic [31:0] mon_e;

  wb_matvec_engine dut (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst),
    .caravel_wb_stb_i(stb), .caravel_wb_cyc_i(cyc), .caravel_wb_we_i(we),
    .caravel_wb_sel_i(sel), .caravel_wb_dat_i(dat_i), .caravel_wb_adr_i(adr),
    .caravel_wb_ack_o(ack), .caravel_wb_dat_o(dat_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every read ack pops the next expectation.
  always @(negedge clk) begin
    if (ack === 1'b1 && rd_flag) begin
      if (q_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read: got %08h expected no read", dat_o);
      end else begin
        mon_n = q_name.pop_front();
        mon_e = q_exp.pop_front();
        check(mon_n, dat_o, mon_e);
      end
    end
  end

  task automatic bus(input logic w, input logic [4:0] off, input logic [31:0] d, output logic ok);
    @(negedge clk);
    rd_flag = ~w; stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + 32'(off); dat_i = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin ok = 1'b1; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic ok;
    bus(1'b1, off, d, ok);
    check("write_ack", 32'(ok), 32'd1);
  endtask

  task automatic rd(input string name, input logic [4:0] off, input logic [31:0] e);
    logic ok;
    q_exp.push_back(e);
    q_name.push_back(name);
    bus(1'b0, off, 32'd0, ok);
    if (!ok) begin
      void'(q_exp.pop_back());
      void'(q_name.pop_back());
      checks++; failures++;
      $display("FAIL %s_ack: got no ack expected ack", name);
    end
  endtask

  task automatic load_w(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    wr(A_WGT, r0); wr(A_WGT, r1); wr(A_WGT, r2);
  endtask

  initial begin
    logic ok;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    rd("rst_status", A_STAT, 32'h0000_0028);
    rd("rst_ctrl", A_CTRL, 32'h0);

    // 1: unsigned basic vector and pipeline timing through STATUS
    load_w(32'h030201, 32'h060504, 32'h090807);
    wr(A_CTRL, 32'd1);
    wr(A_IN, 32'h010101);
    rd("t1_st_load", A_STAT, 32'h0000_1023);
    rd("t1_st_comp", A_STAT, 32'h0001_000B);
    rd("t1_st_done", A_STAT, 32'h0003_0009);
    rd("t1_y0", A_RES, 32'd6);
    rd("t1_y1", A_RES, 32'd15);
    rd("t1_y2", A_RES, 32'd24);
    rd("t1_st_end", A_STAT, 32'h0000_0029);

    // 2: signed
    wr(A_CTRL, 32'd5);
    rd("t2_ctrl", A_CTRL, 32'd5);
    wr(A_IN, 32'h0000FF);
    repeat (8) @(negedge clk);
    rd("t2_y0", A_RES, 32'hFFFF_FFFF);
    rd("t2_y1", A_RES, 32'hFFFF_FFFC);
    rd("t2_y2", A_RES, 32'hFFFF_FFF9);
    rd("t2_st", A_STAT, 32'h0000_0029);

    // 3: input overflow, result FIFO full stall, resume
    wr(A_CTRL, 32'd0);
    wr(A_IN, 32'h000001); wr(A_IN, 32'h000100); wr(A_IN, 32'h010000);
    wr(A_IN, 32'h010101); wr(A_IN, 32'h020202);
    rd("t3_st_inful", A_STAT, 32'h0000_4065);
    wr(A_CTRL, 32'd1);
    repeat (20) @(negedge clk);
    rd("t3_st_stall", A_STAT, 32'h0008_1053);
    rd("t3_r0", A_RES, 32'd1);
    repeat (5) @(negedge clk);
    rd("t3_st_resume", A_STAT, 32'h0008_005B);
    rd("t3_r1", A_RES, 32'd4);  rd("t3_r2", A_RES, 32'd7);
    rd("t3_r3", A_RES, 32'd2);  rd("t3_r4", A_RES, 32'd5);
    rd("t3_r5", A_RES, 32'd8);  rd("t3_r6", A_RES, 32'd3);
    rd("t3_r7", A_RES, 32'd6);  rd("t3_r8", A_RES, 32'd9);
    rd("t3_r9", A_RES, 32'd6);  rd("t3_r10", A_RES, 32'd15);
    rd("t3_r11", A_RES, 32'd24);
    rd("t3_st_end", A_STAT, 32'h0000_0069);

    // 4: unsigned accumulator wrap and overflow flag
    wr(A_CTRL, 32'd2);
    rd("t4_st_clr", A_STAT, 32'h0000_0028);
    load_w(32'hFFFFFF, 32'hFFFFFF, 32'hFFFFFF);
    wr(A_CTRL, 32'd1);
    wr(A_IN, 32'hFFFFFF);
    repeat (8) @(negedge clk);
    rd("t4_y0", A_RES, 32'h0000_FA03);
    rd("t4_y1", A_RES, 32'h0000_FA03);
    rd("t4_y2", A_RES, 32'h0000_FA03);
    rd("t4_st", A_STAT, 32'h0000_00A9);

    // 5: underflow read, ignored extra weight write, out-of-window access
    rd("t5_udf_data", A_RES, 32'd0);
    rd("t5_st_udf", A_STAT, 32'h0000_01A9);
    wr(A_WGT, 32'h010101);
    wr(A_IN, 32'h010101);
    repeat (8) @(negedge clk);
    rd("t5_y0", A_RES, 32'h0000_02FD);
    rd("t5_y1", A_RES, 32'h0000_02FD);
    rd("t5_y2", A_RES, 32'h0000_02FD);
    bus(1'b0, 5'h14, 32'd0, ok);
    check("t5_oow_no_ack", 32'(ok), 32'd0);

    // 6: clear mid-compute, then reset mid-compute
    wr(A_CTRL, 32'd2);
    load_w(32'h030201, 32'h060504, 32'h090807);
    wr(A_CTRL, 32'd1);
    wr(A_IN, 32'h010101);
    repeat (2) @(negedge clk);
    wr(A_CTRL, 32'd2);
    rd("t6_st_clr", A_STAT, 32'h0000_0028);

    load_w(32'h030201, 32'h060504, 32'h090807);
    wr(A_CTRL, 32'd1);
    wr(A_IN, 32'h010101);
    repeat (2) @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_dat", dat_o, 32'd0);
    rd("t6_rst_status", A_STAT, 32'h0000_0028);
    rd("t6_rst_ctrl", A_CTRL, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_matvec_engine.md
Name: wb_matvec_engine

Overview:
Parametrised successor to the fixed 3x3 wishbone TPU. Wishbone slave that holds an NxN weight matrix and accepts input vectors into an input FIFO. For each vector it computes the N dot products y[r] = sum_c W[r][c]*x[c] and queues them in a result FIFO, which software drains by reads. It runs in a single clock domain, with no divided clock and no async FIFO, and supports selectable signed/unsigned arithmetic plus overflow and underflow flags.

Parameters:
BASE_ADDRESS, 32'h3000_0000, base of the 5-word register window
N, 3, vector length and matrix dimension; legal 1..4; N*DW <= 32
DW, 8, element width of weights and inputs
ACC_W, 16, result width; legal DW*2..32
IN_DEPTH, 4, input FIFO depth in vectors; power of 2
RES_DEPTH, 8, result FIFO depth in elements; power of 2, >= N

Ports:
caravel_wb_clk_i  in  1  system clock; all logic on rising edge
caravel_wb_rst_i  in  1  synchronous, active-high reset
caravel_wb_stb_i  in  1  strobe
caravel_wb_cyc_i  in  1  cycle
caravel_wb_we_i  in  1  write enable
caravel_wb_sel_i  in  4  byte select; ignored, full-word access only
caravel_wb_dat_i  in  32  write data
caravel_wb_adr_i  in  32  address
caravel_wb_ack_o  out  1  ack, registered
caravel_wb_dat_o  out  32  read data, registered

Behaviour:
- Reset: ack=0, dat_o=0, both FIFOs empty, weight row count=0, weights_valid=0, CTRL=0, sticky flags=0, FSM=IDLE.
- Bus: a request is stb&cyc&adr in {BASE+0x00,+0x04,+0x08,+0x0C,+0x10}. ack=1 the cycle after the request, only if ack was 0 that cycle, so ack is a 1-cycle pulse and each request completes once. Side effects (push/pop/write) occur in the ack cycle. Out-of-window addresses get no ack.
- 0x00 CTRL (R/W):
  - bit0 run (level).
  - bit1 clear: self-clearing pulse. It empties both FIFOs, sets row count=0, weights_valid=0, sticky flags=0 and FSM=IDLE on the next edge, aborting any compute. It has priority over a simultaneous push.
  - bit2 signed: two's-complement operands, ACC sign-extended on read.
- 0x04 STATUS (RO):
  - b0 weights_valid, b1 busy (FSM!=IDLE), b2 in_full, b3 in_empty, b4 res_full, b5 res_empty.
  - b6 in_ovf (sticky), b7 acc_ovf (sticky), b8 res_udf (sticky).
  - [15:12] in_count, [23:16] res_count.
- 0x08 WEIGHT (WO): loads row w_count, with element c in bits [c*DW+:DW]; then w_count++. After N writes weights_valid=1, and further writes are ignored until clear.
- 0x0C INPUT (WO): pushes one packed vector, same packing. If full, the vector is dropped, in_ovf is set and the bus is still acked.
- 0x10 RESULT (RO): pops one element, returned in bits [ACC_W-1:0] and zero- or sign-extended per the signed bit. If empty, returns 0, sets res_udf and pops nothing.
- FSM:
  - IDLE -> LOAD when run & weights_valid & !in_empty.
  - LOAD: pop the head into x_reg, r=0 -> COMP.
  - COMP: if res_count<RES_DEPTH, compute y[r] combinationally with N parallel multipliers and an adder tree, push it, r++. Otherwise stall in COMP.
  - After pushing r=N-1: go to LOAD if run & !in_empty, else IDLE.
  - Clearing run mid-vector finishes that vector.
- Latency: the pop edge is t; y[0] is pushed at t+1 and y[N-1] at t+N (no stalls). Throughput is N+1 cycles per vector.
- Arithmetic:
  - Products are 2*DW bits; the sum is computed at ACC_W+2 bits and truncated (wrapped) to ACC_W.
  - acc_ovf is set if the full-precision sum does not fit ACC_W. Unsigned: any discarded bit set. Signed: out of signed range.
- Simultaneous push and pop on the same FIFO in one cycle: both occur and the count is unchanged. A push to a full FIFO is never allowed, even with a concurrent pop.
- Pointers wrap modulo depth. Counts run 0..DEPTH inclusive.

Test Plan:
1. Reset, then N=3, weights 0x030201, 0x060504, 0x090807, CTRL=1, INPUT 0x010101 -> busy for 4 cycles; RESULT reads 6, 15, 24; res_empty=1; flags 0.
2. CTRL=5 (signed), same weights, INPUT 0x0000FF -> RESULT reads 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF9; acc_ovf=0.
3. run=0, 5 INPUT writes -> all acked; in_count=4; in_ovf=1. Set run with no reads -> 8 results queued, FSM stalls in COMP with res_full=1. Read 1 -> engine resumes.
4. Unsigned; all weights 0xFF; INPUT 0xFFFFFF -> each result = 0xFA03 (195075 mod 65536); acc_ovf=1.
5. Read RESULT when empty -> data 0, res_udf=1. Write a 4th WEIGHT after valid -> ignored, weights unchanged.
6. Mid-COMP after y[0] is pushed: CTRL=2 -> next cycle busy=0, both FIFOs empty, weights_valid=0. Repeat with caravel_wb_rst_i held 1 cycle -> all registers at reset values, ack=0.
